// File: rtl/serial_addsub16.sv
// Bit-serial add/subtract unit: one full-adder cell evaluated per clock, LSB first.
// Results and flags update only at completion, so the flags register always sees a stable value.
module serial_addsub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             bit_a;
  logic             bit_b;
  logic             sum;
  logic             cell_cout;
  logic [WIDTH-1:0] next_shreg;

  // The single full-adder cell, fed by the bit selected by the counter.
  always_comb begin
    bit_a      = opa[cnt];
    bit_b      = opb[cnt];
    sum        = bit_a ^ bit_b ^ carry;
    cell_cout  = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
    next_shreg = {sum, shreg[WIDTH-1:1]};
  end

  // Subtraction is A + ~B + 1: B is inverted at load time and the +1 enters as the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      shreg  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          shreg <= next_shreg;
          carry <= cell_cout;
          if (cnt == LAST) begin
            // On the MSB step the current carry is the carry into the MSB, so overflow falls out directly.
            result <= next_shreg;
            cout   <= cell_cout;
            zero   <= (next_shreg == '0);
            neg    <= sum;
            ovf    <= carry ^ cell_cout;
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub16.sv
// Scoreboard bench for serial_addsub16: stimulus pushes expected results, a monitor pops them on DONE.
module tb_serial_addsub16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        neg;
  logic        ovf;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;
  logic prev_done;

  serial_addsub16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .zero(zero), .neg(neg), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result_flags", {12'd0, cout, zero, neg, ovf, result},
                    {12'd0, e.c, e.z, e.n, e.v, e.res});
        checkOutput("latency", cyc - e.start_cyc, 32'd16);
      end
      if (prev_done) checkOutput("done_width", 32'd2, 32'd1);
    end
    prev_done = done;
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pushExp(input logic [15:0] r, input logic c, input logic z,
                         input logic n, input logic v, input int sc);
    exp_t e;
    e.res = r; e.c = c; e.z = z; e.n = n; e.v = v; e.start_cyc = sc;
    sb.push_back(e);
  endtask

  // Issues one operation; leaves the bench at #1 after the accepting edge.
  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                               input logic [15:0] r, input logic c, input logic z,
                               input logic n, input logic v);
    waitIdle();
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pushExp(r, c, z, n, v, cyc);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {13'd0, busy, done, cout, zero, neg, ovf, result}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #2;
    checkAllZero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Ignored START mid-operation; previous result must also hold during the run.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    checkOutput("hold_result", {16'd0, result}, 32'h7FFF);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_in_run", {31'd0, busy}, 32'd1);

    // Reset mid-operation aborts with outputs cleared at once.
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    sb.delete();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);

    applyStimulus(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: START held through DONE; second op accepted on the DONE cycle.
    waitIdle();
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    pushExp(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
    a = 16'h0003; b = 16'h0003; sub = 1'b1;
    pushExp(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, cyc + 17);
    repeat (17) @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);

    waitIdle();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
